// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and helpers for the external interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_e;

    localparam int MAX_SRC = 16;

    // Index width for n sources, never narrower than one bit
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-first priority encoder
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = calc_id_w(N)
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    // Scan from the top so the lowest set index is written last
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - external interrupt controller driving the ExtIRQ/ExtIAck/ERet handshake
// Optional IRQ_EDGE_EN selects rising-edge capture; default is level capture.
module ext_irq_ctrl
    import irq_pkg::*;
#(
    parameter int               N_SRC    = 4,
    parameter logic [N_SRC-1:0] MASK_RST = '0,
    localparam int              ID_W     = calc_id_w(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic             ExtIRQ,
    input  logic             ExtIAck,
    input  logic             ERet,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_clr;
    logic             win_valid;
    logic [ID_W-1:0]  win_idx;

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0] src_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev_q <= '0;
        end else begin
            src_prev_q <= irq_src;
        end
    end

    assign pend_set = irq_src & ~src_prev_q;
`else
    assign pend_set = irq_src;
`endif

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (pending_q & ~mask_q),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        pend_clr = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    irq_id_d = win_idx;
                end
            end
            REQ: begin
                if (ExtIAck) begin
                    state_d  = SVC;
                    pend_clr = N_SRC'(1) << irq_id_q;
                end
            end
            SVC: begin
                if (ERet) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new capture in the acknowledge cycle must not be lost
        pending_d = (pending_q & ~pend_clr) | pend_set;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            irq_id_q  <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign ExtIRQ     = (state_q == REQ);
    assign in_service = (state_q == SVC);
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - self-checking bench for ext_irq_ctrl with a behavioural model
module tb_ext_irq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic         ExtIRQ;
    logic         ExtIAck = 1'b0;
    logic         ERet = 1'b0;
    logic [1:0]   irq_id;
    logic         in_service;
    logic [N-1:0] pending;
    logic [N-1:0] mask;

    int checks = 0;
    int failures = 0;

    // Model: 0 = waiting, 1 = request raised, 2 = being serviced
    int m_phase;
    int m_id;
    bit m_pend [N];
    bit m_mask [N];
    bit m_prev [N];

    ext_irq_ctrl #(.N_SRC(N), .MASK_RST('0)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ExtIRQ     (ExtIRQ),
        .ExtIAck    (ExtIAck),
        .ERet       (ERet),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit v [N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_id    = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_mask[i] = 0;
            m_prev[i] = 0;
        end
    endtask

    task automatic model_edge();
        int  winner;
        bit  acked;
        bit  fresh;
        winner = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && !m_mask[i]) winner = i;
        acked = (m_phase == 1) && ExtIAck;
        for (int i = 0; i < N; i++) begin
`ifdef IRQ_EDGE_EN
            fresh = irq_src[i] && !m_prev[i];
`else
            fresh = irq_src[i];
`endif
            if (acked && i == m_id) m_pend[i] = 0;
            if (fresh) m_pend[i] = 1;
            m_prev[i] = irq_src[i];
            if (mask_we) m_mask[i] = mask_wdata[i];
        end
        if (m_phase == 0 && winner >= 0) begin
            m_phase = 1;
            m_id    = winner;
        end else if (acked) begin
            m_phase = 2;
        end else if (m_phase == 2 && ERet) begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("ExtIRQ", 32'(ExtIRQ), 32'(m_phase == 1));
        chk("in_service", 32'(in_service), 32'(m_phase == 2));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("pending", 32'(pending), 32'(pack(m_pend)));
        chk("mask", 32'(mask), 32'(pack(m_mask)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Reset lands between clock edges and must act without waiting for one
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_ExtIRQ", 32'(ExtIRQ), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic pulse_ack();
        ExtIAck = 1'b1; cyc(); ExtIAck = 1'b0;
    endtask

    task automatic pulse_eret();
        ERet = 1'b1; cyc(); ERet = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we = 1'b1; mask_wdata = v; cyc(); mask_we = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single source latency and handshake
        irq_src = 4'b0100; cyc(); irq_src = '0;
        chk("lat1_ExtIRQ", 32'(ExtIRQ), 32'd0);
        cyc();
        chk("lat2_ExtIRQ", 32'(ExtIRQ), 32'd1);
        chk("single_id", 32'(irq_id), 32'd2);
        pulse_ack();
        chk("ack_in_service", 32'(in_service), 32'd1);
        chk("ack_pending2", 32'(pending[2]), 32'd0);
        pulse_eret();
        chk("eret_in_service", 32'(in_service), 32'd0);

        // Priority between two simultaneous sources
        irq_src = 4'b1010; cyc(); irq_src = '0; cyc();
        chk("prio_first", 32'(irq_id), 32'd1);
        pulse_ack();
        pulse_eret();
        chk("no_back_to_back", 32'(ExtIRQ), 32'd0);
        cyc();
        chk("prio_second", 32'(irq_id), 32'd3);
        chk("prio_second_req", 32'(ExtIRQ), 32'd1);
        pulse_ack();
        pulse_eret();

        // Masking
        write_mask(4'b0010);
        irq_src = 4'b0010; cyc(); irq_src = '0; cyc(); cyc();
        chk("masked_no_req", 32'(ExtIRQ), 32'd0);
        write_mask(4'b0000);
        cyc();
        chk("unmask_req", 32'(ExtIRQ), 32'd1);
        chk("unmask_id", 32'(irq_id), 32'd1);
        write_mask(4'b0010);
        cyc();
        chk("mask_in_req_keeps", 32'(ExtIRQ), 32'd1);
        pulse_ack();
        pulse_eret();
        write_mask(4'b0000);

        // Protocol abuse: ack while idle, eret while requesting
        write_mask(4'b0010);
        irq_src = 4'b0010; cyc(); irq_src = '0; cyc();
        pulse_ack();
        chk("idle_ack_pending", 32'(pending), 32'b0010);
        chk("idle_ack_state", 32'(in_service), 32'd0);
        write_mask(4'b0000);
        cyc();
        pulse_eret();
        chk("req_eret_state", 32'(ExtIRQ), 32'd1);
        chk("req_eret_pending", 32'(pending), 32'b0010);
        pulse_ack();
        pulse_eret();

        // New capture in the same cycle as its acknowledge
        irq_src = 4'b0001; cyc(); irq_src = '0; cyc();
        chk("sim_id", 32'(irq_id), 32'd0);
        irq_src = 4'b0001; ExtIAck = 1'b1; cyc(); irq_src = '0; ExtIAck = 1'b0;
        chk("set_wins_clear", 32'(pending[0]), 32'd1);
        pulse_eret();
        cyc();
        chk("repend_req", 32'(ExtIRQ), 32'd1);
        pulse_ack();
        pulse_eret();

        // Line held high across the acknowledge
        irq_src = 4'b1000;
        cyc(); cyc();
        pulse_ack();
        cyc(); cyc();
`ifdef IRQ_EDGE_EN
        chk("held_pends_once", 32'(pending[3]), 32'd0);
`else
        chk("held_repends", 32'(pending[3]), 32'd1);
`endif
        irq_src = '0;
        pulse_eret();
        for (int k = 0; k < 6; k++) begin
            ExtIAck = (k % 2 == 1); ERet = (k % 2 == 0); cyc();
        end
        ExtIAck = 1'b0; ERet = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            irq_src    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom);
            ExtIAck    = ($urandom_range(0, 3) == 0);
            ERet       = ($urandom_range(0, 5) == 0);
            cyc();
        end
        irq_src = '0; mask_we = 1'b0; ExtIAck = 1'b0; ERet = 1'b0;

        // Reset while in service
        apply_reset();
        irq_src = 4'b0001; cyc(); irq_src = '0; cyc();
        pulse_ack();
        write_mask(4'b1111);
        irq_src = 4'b0110; cyc(); irq_src = '0;
        chk("pre_rst_in_service", 32'(in_service), 32'd1);
        apply_reset();
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        cyc();
        chk("post_rst_idle", 32'(ExtIRQ), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
